// File: rtl/alu_serial_sequencer.sv
// Bit-serial sequencer that walks one external 1-bit ALU slice LSB-first over WIDTH cycles.
// Define ALU_SEQ_INBUF_EN to add a one-entry input holding buffer.
module alu_serial_sequencer #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [4:0]       in_ctrl,
  output logic             s_a,
  output logic             s_b,
  output logic             s_ainv,
  output logic             s_binv,
  output logic             s_cin,
  output logic             s_less,
  output logic [2:0]       s_op,
  input  logic             s_result,
  input  logic             s_carryout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] res_sh;
  logic [4:0]       ctrl_q;
  logic [2:0]       op_q, slice_op;
  logic [CNT_W-1:0] cnt;
  logic             carry_q;
  logic             pending, chain, start, running, last_bit;
  logic [WIDTH-1:0] launch_a, launch_b;
  logic [4:0]       launch_ctrl;
  logic [WIDTH-1:0] full_word, final_result;
  logic             ovf_bit, arith;

  assign op_q      = ctrl_q[2:0];
  assign running   = (state == RUN);
  assign last_bit  = running && (cnt == CNT_W'(WIDTH-1));
  assign out_valid = (state == DONE);

`ifdef ALU_SEQ_INBUF_EN
  logic             buf_full, buf_load;
  logic [WIDTH-1:0] buf_a, buf_b;
  logic [4:0]       buf_ctrl;

  assign in_ready    = !buf_full;
  assign pending     = buf_full || in_valid;
  assign chain       = pending;
  assign launch_a    = buf_full ? buf_a : in_a;
  assign launch_b    = buf_full ? buf_b : in_b;
  assign launch_ctrl = buf_full ? buf_ctrl : in_ctrl;
  // A request arriving while nothing can start is parked; direct launches bypass the buffer.
  assign buf_load    = in_valid && !buf_full && !start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_full <= 1'b0;
      buf_a    <= '0;
      buf_b    <= '0;
      buf_ctrl <= '0;
    end else if (start && buf_full) begin
      buf_full <= 1'b0;
    end else if (buf_load) begin
      buf_full <= 1'b1;
      buf_a    <= in_a;
      buf_b    <= in_b;
      buf_ctrl <= in_ctrl;
    end
  end
`else
  assign in_ready    = (state == IDLE);
  assign pending     = in_valid;
  assign chain       = 1'b0;
  assign launch_a    = in_a;
  assign launch_b    = in_b;
  assign launch_ctrl = in_ctrl;
`endif

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (pending) begin
          start     = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
          if (chain) begin
            start     = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // SLT borrows the adder path; undefined opcodes run as AND and are zeroed at the end.
  always_comb begin
    slice_op = op_q;
    if (op_q == OP_SLT)     slice_op = OP_ADD;
    else if (op_q > OP_XOR) slice_op = OP_AND;
  end

  assign s_a    = running & a_sh[0];
  assign s_b    = running & b_sh[0];
  assign s_ainv = running & ctrl_q[4];
  assign s_binv = running & ctrl_q[3];
  assign s_cin  = running & carry_q;
  assign s_less = 1'b0;
  assign s_op   = running ? slice_op : 3'b000;

  assign full_word = {s_result, res_sh};
  assign ovf_bit   = carry_q ^ s_carryout;
  assign arith     = (op_q == OP_ADD) || (op_q == OP_SLT);

  always_comb begin
    final_result = '0;
    if (op_q == OP_SLT)      final_result = {{(WIDTH-1){1'b0}}, s_result ^ ovf_bit};
    else if (op_q <= OP_XOR) final_result = full_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh         <= '0;
      b_sh         <= '0;
      res_sh       <= '0;
      ctrl_q       <= '0;
      cnt          <= '0;
      carry_q      <= 1'b0;
      out_result   <= '0;
      out_carry    <= 1'b0;
      out_overflow <= 1'b0;
      out_zero     <= 1'b0;
    end else if (start) begin
      a_sh    <= launch_a;
      b_sh    <= launch_b;
      ctrl_q  <= launch_ctrl;
      cnt     <= '0;
      carry_q <= launch_ctrl[3];
    end else if (running) begin
      carry_q <= s_carryout;
      res_sh  <= {s_result, res_sh[WIDTH-2:1]};
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      cnt     <= cnt + 1'b1;
      if (last_bit) begin
        out_result   <= final_result;
        out_carry    <= arith & s_carryout;
        out_overflow <= arith & ovf_bit;
        out_zero     <= (final_result == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Self-checking bench for alu_serial_sequencer: models the 1-bit slice and compares against a word-level ALU model.
module tb_alu_serial_sequencer;

  localparam int WIDTH = 24;
`ifdef ALU_SEQ_INBUF_EN
  localparam int PERIOD = WIDTH + 1;
`else
  localparam int PERIOD = WIDTH + 2;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [4:0]       in_ctrl = '0;
  logic             s_a, s_b, s_ainv, s_binv, s_cin, s_less;
  logic [2:0]       s_op;
  logic             s_result, s_carryout;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_result;
  logic             out_carry, out_overflow, out_zero;
  logic             slice_a, slice_b;
  logic [8:0]       s_bus;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_serial_sequencer #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ctrl(in_ctrl),
    .s_a(s_a), .s_b(s_b), .s_ainv(s_ainv), .s_binv(s_binv),
    .s_cin(s_cin), .s_less(s_less), .s_op(s_op),
    .s_result(s_result), .s_carryout(s_carryout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry),
    .out_overflow(out_overflow), .out_zero(out_zero)
  );

  assign s_bus = {s_a, s_b, s_ainv, s_binv, s_cin, s_less, s_op};

  // Behavioural 1-bit ALU slice sitting downstream of the sequencer.
  always_comb begin
    slice_a    = s_a ^ s_ainv;
    slice_b    = s_b ^ s_binv;
    s_carryout = (slice_a & slice_b) | (slice_a & s_cin) | (slice_b & s_cin);
    case (s_op)
      3'b000:  s_result = slice_a & slice_b;
      3'b001:  s_result = slice_a | slice_b;
      3'b010:  s_result = slice_a ^ slice_b ^ s_cin;
      3'b011:  s_result = s_less;
      3'b100:  s_result = slice_a ^ slice_b;
      default: s_result = 1'b0;
    endcase
  end

  // Word-level reference: whole-operand arithmetic, no bit walking.
  function automatic void ref_alu(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic [4:0] ctrl, output logic [WIDTH-1:0] r,
                                  output logic c, output logic v, output logic z);
    logic [WIDTH-1:0] aa, bb;
    logic [WIDTH:0]   sum;
    logic             ov;
    aa  = ctrl[4] ? ~a : a;
    bb  = ctrl[3] ? ~b : b;
    sum = {1'b0, aa} + {1'b0, bb} + {{WIDTH{1'b0}}, ctrl[3]};
    ov  = (aa[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != aa[WIDTH-1]);
    c = 1'b0;
    v = 1'b0;
    case (ctrl[2:0])
      3'd0: r = aa & bb;
      3'd1: r = aa | bb;
      3'd2: begin r = sum[WIDTH-1:0]; c = sum[WIDTH]; v = ov; end
      3'd3: begin r = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ov}; c = sum[WIDTH]; v = ov; end
      3'd4: r = aa ^ bb;
      default: r = '0;
    endcase
    z = (r == '0);
  endfunction

  function automatic logic [2:0] exp_sop(input logic [4:0] ctrl);
    if (ctrl[2:0] == 3'd3) return 3'd2;
    if (ctrl[2:0] > 3'd4)  return 3'd0;
    return ctrl[2:0];
  endfunction

  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [4:0] ctrl);
    int n;
    n = 0;
    in_a = a; in_b = b; in_ctrl = ctrl; in_valid = 1'b1;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("[TB] FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    if (!out_valid) begin
      checks++; errors++;
      $display("[TB] FAIL valid_timeout: out_valid=%b after %0d cycles, required 1", out_valid, lat);
    end
  endtask

  task automatic release_result;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, out_result, out_carry, out_overflow, out_zero, s_bus} !==
        {1'b1, 1'b0, {WIDTH{1'b0}}, 3'b000, 9'd0}) begin
      errors++;
      $display("[TB] FAIL reset_held: rdy=%b vld=%b res=%h flags=%b%b%b s=%h, required 1 0 0 000 0",
               in_ready, out_valid, out_result, out_carry, out_overflow, out_zero, s_bus);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, s_bus} !== {1'b1, 1'b0, 9'd0}) begin
      errors++;
      $display("[TB] FAIL reset_release: rdy=%b vld=%b s=%h, required 1 0 000", in_ready, out_valid, s_bus);
    end
  endtask

  typedef struct {
    logic [WIDTH-1:0] a, b, res;
    logic [4:0]       ctrl;
    logic             c, v, z;
  } vec_t;

  task automatic test_directed;
    vec_t vecs[5];
    int lat;
    logic [2:0] sop;
    vecs[0] = '{a: 24'h000001, b: 24'hFFFFFF, res: 24'h000000, ctrl: 5'b00010, c: 1'b1, v: 1'b0, z: 1'b1};
    vecs[1] = '{a: 24'h800000, b: 24'h000001, res: 24'h7FFFFF, ctrl: 5'b01010, c: 1'b1, v: 1'b1, z: 1'b0};
    vecs[2] = '{a: 24'hFFFFFF, b: 24'h000001, res: 24'h000001, ctrl: 5'b01011, c: 1'b1, v: 1'b0, z: 1'b0};
    vecs[3] = '{a: 24'h000005, b: 24'h000003, res: 24'h000000, ctrl: 5'b01011, c: 1'b1, v: 1'b0, z: 1'b1};
    vecs[4] = '{a: 24'h0F0F0F, b: 24'h00FF00, res: 24'hF000F0, ctrl: 5'b11000, c: 1'b0, v: 1'b0, z: 1'b0};
    for (int i = 0; i < 5; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].ctrl);
      sop = s_op;
      checks++;
      if (sop !== exp_sop(vecs[i].ctrl)) begin
        errors++;
        $display("[TB] FAIL directed_sop[%0d]: got %b, required %b", i, sop, exp_sop(vecs[i].ctrl));
      end
      wait_valid(lat);
      checks++;
      if (lat != WIDTH) begin
        errors++;
        $display("[TB] FAIL directed_latency[%0d]: got %0d edges, required %0d", i, lat, WIDTH);
      end
      checks++;
      if ({out_result, out_carry, out_overflow, out_zero} !== {vecs[i].res, vecs[i].c, vecs[i].v, vecs[i].z}) begin
        errors++;
        $display("[TB] FAIL directed_result[%0d]: got %h c%b v%b z%b, required %h c%b v%b z%b", i,
                 out_result, out_carry, out_overflow, out_zero, vecs[i].res, vecs[i].c, vecs[i].v, vecs[i].z);
      end
      release_result();
    end
  endtask

  task automatic test_backpressure;
    logic [WIDTH-1:0] a, b, r;
    logic [4:0] ctrl;
    logic c, v, z;
    int lat;
    a = 24'($urandom); b = 24'($urandom); ctrl = 5'b01010;
    ref_alu(a, b, ctrl, r, c, v, z);
    start_op(a, b, ctrl);
    wait_valid(lat);
`ifdef ALU_SEQ_INBUF_EN
    begin
      logic [WIDTH-1:0] a2, b2, r2;
      logic c2, v2, z2;
      a2 = 24'($urandom); b2 = 24'($urandom);
      ref_alu(a2, b2, 5'b00010, r2, c2, v2, z2);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL bp_buf_ready: got %b, required 1", in_ready);
      end
      in_a = a2; in_b = b2; in_ctrl = 5'b00010; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        checks++;
        if ({out_valid, in_ready, out_result, out_carry, out_overflow, out_zero} !== {1'b1, 1'b0, r, c, v, z}) begin
          errors++;
          $display("[TB] FAIL bp_hold[%0d]: vld=%b rdy=%b res=%h c%b v%b z%b, required 1 0 %h c%b v%b z%b",
                   i, out_valid, in_ready, out_result, out_carry, out_overflow, out_zero, r, c, v, z);
        end
      end
      release_result();
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        errors++;
        $display("[TB] FAIL bp_chain_start: vld=%b rdy=%b, required 0 1", out_valid, in_ready);
      end
      wait_valid(lat);
      checks++;
      if (lat != WIDTH || {out_result, out_carry, out_overflow, out_zero} !== {r2, c2, v2, z2}) begin
        errors++;
        $display("[TB] FAIL bp_chained: lat=%0d res=%h c%b v%b z%b, required %0d %h c%b v%b z%b",
                 lat, out_result, out_carry, out_overflow, out_zero, WIDTH, r2, c2, v2, z2);
      end
      release_result();
    end
`else
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, out_result, out_carry, out_overflow, out_zero} !== {1'b1, 1'b0, r, c, v, z}) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d]: vld=%b rdy=%b res=%h c%b v%b z%b, required 1 0 %h c%b v%b z%b",
                 i, out_valid, in_ready, out_result, out_carry, out_overflow, out_zero, r, c, v, z);
      end
    end
    release_result();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL bp_release: vld=%b rdy=%b, required 0 1", out_valid, in_ready);
    end
`endif
  endtask

  task automatic test_reset_mid_run;
    int lat, seen;
    start_op(24'hABCDEF, 24'h123456, 5'b00010);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, s_bus} !== {1'b1, 1'b0, 9'd0}) begin
      errors++;
      $display("[TB] FAIL midrun_reset: rdy=%b vld=%b s=%h, required 1 0 000", in_ready, out_valid, s_bus);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("[TB] FAIL midrun_no_valid: got %0d valid cycles, required 0", seen);
    end
    start_op(24'h000002, 24'h000003, 5'b00010);
    wait_valid(lat);
    checks++;
    if ({out_result, out_carry, out_overflow, out_zero} !== {24'h000005, 3'b000}) begin
      errors++;
      $display("[TB] FAIL midrun_fresh_add: got %h c%b v%b z%b, required 000005 c0 v0 z0",
               out_result, out_carry, out_overflow, out_zero);
    end
    release_result();
  endtask

  task automatic test_random;
    logic [WIDTH-1:0] a, b, r;
    logic [4:0] ctrl;
    logic c, v, z;
    logic [8:0] s_exp, s_got;
    int lat;
    for (int i = 0; i < 30; i++) begin
      a = 24'($urandom); b = 24'($urandom); ctrl = 5'($urandom_range(0, 31));
      ref_alu(a, b, ctrl, r, c, v, z);
      start_op(a, b, ctrl);
      s_got = s_bus;
      s_exp = {a[0], b[0], ctrl[4], ctrl[3], ctrl[3], 1'b0, exp_sop(ctrl)};
      checks++;
      if (s_got !== s_exp) begin
        errors++;
        $display("[TB] FAIL random_slice_drive[%0d]: got %b, required %b", i, s_got, s_exp);
      end
      wait_valid(lat);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      checks++;
      if ({out_valid, out_result, out_carry, out_overflow, out_zero} !== {1'b1, r, c, v, z}) begin
        errors++;
        $display("[TB] FAIL random_result[%0d] ctrl=%b a=%h b=%h: vld=%b got %h c%b v%b z%b, required %h c%b v%b z%b",
                 i, ctrl, a, b, out_valid, out_result, out_carry, out_overflow, out_zero, r, c, v, z);
      end
      release_result();
    end
  endtask

  task automatic test_back_to_back;
    logic [WIDTH+2:0] exp_q[$];
    logic [WIDTH+2:0] exp_w;
    logic [WIDTH-1:0] na, nb, r;
    logic [4:0] nc;
    logic c, v, z, will_acc;
    int sent, got, cyc, last_cyc;
    sent = 0; got = 0; cyc = 0; last_cyc = -1;
    na = 24'($urandom); nb = 24'($urandom); nc = 5'($urandom_range(0, 4));
    out_ready = 1'b1;
    while (got < 6 && cyc < 1000) begin
      if (sent < 6) begin
        in_valid = 1'b1; in_a = na; in_b = nb; in_ctrl = nc;
      end else begin
        in_valid = 1'b0;
      end
      will_acc = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (will_acc) begin
        ref_alu(na, nb, nc, r, c, v, z);
        exp_q.push_back({r, c, v, z});
        sent++;
        na = 24'($urandom); nb = 24'($urandom); nc = 5'($urandom_range(0, 4));
      end
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL b2b_unexpected: got result %h with nothing outstanding, required none", out_result);
        end else begin
          exp_w = exp_q.pop_front();
          if ({out_result, out_carry, out_overflow, out_zero} !== exp_w) begin
            errors++;
            $display("[TB] FAIL b2b_result[%0d]: got %h, required %h", got,
                     {out_result, out_carry, out_overflow, out_zero}, exp_w);
          end
        end
        if (last_cyc >= 0) begin
          checks++;
          if (cyc - last_cyc != PERIOD) begin
            errors++;
            $display("[TB] FAIL b2b_period[%0d]: got %0d cycles, required %0d", got, cyc - last_cyc, PERIOD);
          end
        end
        last_cyc = cyc;
        got++;
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (got < 6) begin
      checks++; errors++;
      $display("[TB] FAIL b2b_timeout: got %0d results, required 6", got);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
